// File: rtl/alu_serial_if.sv
// alu_serial_if: start/ready/done handshake and operand/result bus for alu_serial.
//   master (requester): drives start, command, a, b; observes ready, done, result, flags.
//   slave  (alu_serial): the reverse.
//   WIDTH must match the WIDTH of the alu_serial instance attached to it.
interface alu_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       command;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, command, a, b,
    input  ready, done, result, carryout, overflow, zero
  );

  modport slave (
    input  start, command, a, b,
    output ready, done, result, carryout, overflow, zero
  );
endinterface

// File: rtl/alu_serial.sv
// alu_serial: multi-cycle ALU evaluating SLICE bits per cycle over WIDTH-bit operands.
// Carry and zero are chained across beats in registers; operands are shifted down
// one slice per beat and the result is shifted in from the top.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - alu_serial_if.slave: start/command/a/b in; ready/done/result/carryout/overflow/zero out
// Commands: 000 add, 001 sub, 010 xor, 011 slt, 100 and, 101 nand, 110 nor, 111 or.
// Optional feature macro ALU_SERIAL_LOGIC_BYPASS_EN: when defined, logic commands are
// evaluated full-width on the first RUN cycle (done 2 cycles after start); when undefined
// every command takes the full N-beat path.
module alu_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic         clk,
  input  logic         reset,
  alu_serial_if.slave  bus
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = WIDTH - SLICE;

`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  logic [1:0]       state_q, state_nxt;
  logic [KW-1:0]    k_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic             zacc_q;
  logic [RW-1:0]    res_q;

  logic             ready_q, done_q, carryout_q, overflow_q, zero_q;
  logic [WIDTH-1:0] result_q;

  logic [SLICE-1:0] a_s, b_s, slice_res;
  logic [SLICE:0]   sum_s;
  logic [WIDTH-1:0] full_res, logic_full;
  logic             msb_cin, ovf_c, slt_bit;
  logic             arith_c, last_beat_c, finish_c, sub_like_c;

  // Beat arithmetic on the low slice of the shifted operands
  always_comb begin
    a_s      = a_q[SLICE-1:0];
    b_s      = b_q[SLICE-1:0];
    sum_s    = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
    case (op_q)
      CMD_XOR:  slice_res = a_s ^ b_s;
      CMD_AND:  slice_res = a_s & b_s;
      CMD_NAND: slice_res = ~(a_s & b_s);
      CMD_NOR:  slice_res = ~(a_s | b_s);
      CMD_OR:   slice_res = a_s | b_s;
      default:  slice_res = sum_s[SLICE-1:0];
    endcase
    full_res = {slice_res, res_q};
    // Carry into the MSB recovered from the sum bit; only meaningful on the last beat
    msb_cin  = a_s[SLICE-1] ^ b_s[SLICE-1] ^ sum_s[SLICE-1];
    ovf_c    = msb_cin ^ sum_s[SLICE];
    slt_bit  = sum_s[SLICE-1] ^ ovf_c;
  end

  // Full-width logic result used only by the bypass path
  always_comb begin
    case (op_q)
      CMD_XOR:  logic_full = a_q ^ b_q;
      CMD_AND:  logic_full = a_q & b_q;
      CMD_NAND: logic_full = ~(a_q & b_q);
      CMD_NOR:  logic_full = ~(a_q | b_q);
      default:  logic_full = a_q | b_q;
    endcase
  end

  // Control decodes
  always_comb begin
    arith_c     = (op_q == CMD_ADD) || (op_q == CMD_SUB) || (op_q == CMD_SLT);
    sub_like_c  = (bus.command == CMD_SUB) || (bus.command == CMD_SLT);
    last_beat_c = (k_q == KW'(N - 1));
    finish_c    = last_beat_c || (BYPASS && !arith_c);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (finish_c)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q        <= '0;
      op_q       <= CMD_ADD;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      zacc_q     <= 1'b0;
      res_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= sub_like_c ? ~bus.b : bus.b;
            op_q    <= bus.command;
            carry_q <= sub_like_c;
            zacc_q  <= 1'b0;
            k_q     <= '0;
            ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          res_q   <= full_res[WIDTH-1:SLICE];
          carry_q <= sum_s[SLICE];
          zacc_q  <= zacc_q | (|slice_res);
          k_q     <= k_q + KW'(1);
          if (finish_c) begin
            done_q <= 1'b1;
            if (!arith_c) begin
              carryout_q <= 1'b0;
              overflow_q <= 1'b0;
              if (BYPASS) begin
                result_q <= logic_full;
                zero_q   <= ~(|logic_full);
              end else begin
                result_q <= full_res;
                zero_q   <= ~(zacc_q | (|slice_res));
              end
            end else begin
              carryout_q <= sum_s[SLICE];
              overflow_q <= ovf_c;
              if (op_q == CMD_SLT) begin
                result_q <= {{(WIDTH-1){1'b0}}, slt_bit};
                zero_q   <= ~slt_bit;
              end else begin
                result_q <= full_res;
                zero_q   <= ~(zacc_q | (|slice_res));
              end
            end
          end
        end
        S_DONE: ready_q <= 1'b1;
        default: ready_q <= 1'b1;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.carryout = carryout_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vectors for alu_serial (WIDTH=32, SLICE=4) checked against an
// arithmetic reference model every cycle, plus hand-computed literal expectations.
module tb_alu_serial;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;
  localparam int N = W / S;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_serial_if #(.WIDTH(W)) bus ();

  alu_serial #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {zero, overflow, carryout, result} from plain arithmetic
  function automatic logic [34:0] ref_op(input logic [2:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] full;
    logic [31:0] res;
    logic co, ovf;
    full = '0; co = 1'b0; ovf = 1'b0;
    case (cmd)
      3'b000: begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = (a[31] == b[31]) && (full[31] != a[31]);
      end
      3'b001, 3'b011: begin
        full = {1'b0, a} + {1'b0, ~b} + 33'd1;
        ovf  = (a[31] != b[31]) && (full[31] != a[31]);
      end
      default: ;
    endcase
    case (cmd)
      3'b000, 3'b001: begin res = full[31:0]; co = full[32]; end
      3'b011: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; co = full[32]; end
      3'b010: res = a ^ b;
      3'b100: res = a & b;
      3'b101: res = ~(a & b);
      3'b110: res = ~(a | b);
      default: res = a | b;
    endcase
    ref_op = {(res == 32'd0), ovf, co, res};
  endfunction

  function automatic int lat_of(input logic [2:0] cmd);
`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
    if (!(cmd == 3'b000 || cmd == 3'b001 || cmd == 3'b011)) return 1;
`endif
    return N;
  endfunction

  // Model state: what the outputs must be after each edge
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_rem   = 0;
  logic        m_ready, m_done, m_co, m_ovf, m_zero;
  logic [31:0] m_res;
  logic [34:0] pend;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b1; m_busy = 1'b0; m_rem = 0;
      m_ready = 1'b1; m_done = 1'b0;
      m_res = '0; m_co = 1'b0; m_ovf = 1'b0; m_zero = 1'b1;
    end else if (m_valid) begin
      if (!m_busy) begin
        m_done = 1'b0;
        if (bus.start) begin
          m_busy = 1'b1; m_ready = 1'b0;
          m_rem = lat_of(bus.command);
          pend = ref_op(bus.command, bus.a, bus.b);
        end
      end else if (m_rem == 0) begin
        m_busy = 1'b0; m_ready = 1'b1; m_done = 1'b0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          {m_zero, m_ovf, m_co, m_res} = pend;
        end
      end
    end
  end

  // Compare process, away from the active edge
  initial forever begin
    @(negedge clk);
    if (bus.done === 1'b1) n_done++;
    if (m_valid) begin
      chk("ready",    bus.ready,    m_ready);
      chk("done",     bus.done,     m_done);
      chk("result",   bus.result,   m_res);
      chk("carryout", bus.carryout, m_co);
      chk("overflow", bus.overflow, m_ovf);
      chk("zero",     bus.zero,     m_zero);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Issue one operation from a negedge; returns cycles from start cycle to done
  task automatic do_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    bus.start = 1'b1; bus.command = cmd; bus.a = a; bus.b = b;
    @(negedge clk);
    lat = 1;
    bus.start = 1'b0;
    bus.command = 3'($urandom_range(0, 7));
    bus.a = $urandom; bus.b = $urandom;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 32'(lat), 32'(lat_of(cmd)));
  endtask

  int lat, d0;
  int lat_logic;

  initial begin
`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
    lat_logic = 2;
`else
    lat_logic = 9;
`endif
    reset = 1'b1; bus.start = 1'b0; bus.command = 3'd0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    reset = 1'b0;
    @(negedge clk);

    // 1: add wraps to zero with carry
    do_op(3'b000, 32'h0000_0001, 32'hFFFF_FFFF, lat);
    chk("t1_latency", 32'(lat), 9);
    chk("t1_result", bus.result, 32'h0);
    chk("t1_carry", bus.carryout, 1);
    chk("t1_zero", bus.zero, 1);
    chk("t1_ovf", bus.overflow, 0);
    @(negedge clk);
    chk("t1_ready_back", bus.ready, 1);

    // 2: sub with signed overflow
    do_op(3'b001, 32'h8000_0000, 32'h0000_0001, lat);
    chk("t2_result", bus.result, 32'h7FFF_FFFF);
    chk("t2_ovf", bus.overflow, 1);
    chk("t2_carry", bus.carryout, 1);
    chk("t2_zero", bus.zero, 0);
    @(negedge clk);

    // 3: slt
    do_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    chk("t3a_result", bus.result, 1);
    chk("t3a_zero", bus.zero, 0);
    @(negedge clk);
    do_op(3'b011, 32'd5, 32'd5, lat);
    chk("t3b_result", bus.result, 0);
    chk("t3b_zero", bus.zero, 1);
    @(negedge clk);

    // 6: nor, latency depends on bypass build
    do_op(3'b110, 32'h0, 32'h0, lat);
    chk("t6_latency", 32'(lat), 32'(lat_logic));
    chk("t6_result", bus.result, 32'hFFFF_FFFF);
    chk("t6_carry", bus.carryout, 0);
    chk("t6_ovf", bus.overflow, 0);
    @(negedge clk);

    // Remaining commands and an add overflow, checked by the model
    do_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, lat); @(negedge clk);
    chk("add_ovf_result", bus.result, 32'h8000_0000);
    do_op(3'b010, 32'hA5A5_0F0F, 32'hFFFF_0000, lat); @(negedge clk);
    chk("xor_result", bus.result, 32'h5A5A_0F0F);
    do_op(3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, lat); @(negedge clk);
    do_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat); @(negedge clk);
    do_op(3'b111, 32'h0000_0000, 32'h0000_0000, lat); @(negedge clk);
    do_op(3'b011, 32'h0000_0002, 32'h8000_0000, lat); @(negedge clk);
    do_op(3'b001, 32'd3, 32'd10, lat); @(negedge clk);

    // 4: start while busy is ignored
    d0 = n_done;
    bus.start = 1'b1; bus.command = 3'b000; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.command = 3'b001; bus.a = 32'd9; bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("t4_result", bus.result, 32'd7);
    repeat (3) @(negedge clk);
    chk("t4_done_count", 32'(n_done - d0), 1);

    // 5: reset mid-run discards the operation
    d0 = n_done;
    bus.start = 1'b1; bus.command = 3'b111; bus.a = 32'h0000_00F0; bus.b = 32'h0000_000F;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_ready", bus.ready, 1);
    chk("t5_result", bus.result, 0);
    chk("t5_zero", bus.zero, 1);
    repeat (12) @(negedge clk);
    chk("t5_no_done", 32'(n_done - d0), 0);
    do_op(3'b000, 32'd100, 32'd23, lat);
    chk("t5_after_result", bus.result, 32'd123);
    chk("t5_after_latency", 32'(lat), 9);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
